mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL provide the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- multStart  in  1  one-cycle request from Control: signed multiply a*b.
- divStart  in  1  one-cycle request from Control: signed divide a/b.
- a  in  32  operand A (multiplicand / dividend); sampled only on an accepted start.
- b  in  32  operand B (multiplier / divisor); sampled only on an accepted start.
- hi  out  32  mult: product[63:32]; div: remainder.
- lo  out  32  mult: product[31:0]; div: quotient.
- busy  out  1  high while an operation is in progress (MULT, DIV, DONE states).
- done  out  1  one-cycle completion pulse; hi/lo/divZero valid in that cycle.
- divZero  out  1  high with done when a divide had b == 0; held until the next accepted start.

Function
REQ-002 The FSM SHALL have states IDLE, MULT, DIV and DONE.
REQ-003 In IDLE, multStart=1 SHALL latch a/b, clear the iteration counter and move to MULT; divStart=1 (with multStart=0) SHALL do the same and move to DIV.
REQ-004 When multStart and divStart are both high in IDLE, multiply SHALL win and divStart SHALL be dropped.
REQ-005 A start seen outside IDLE SHALL be ignored, with no effect on state, operands or outputs.
REQ-006 MULT SHALL run radix-2 Booth on a 65-bit {acc, multiplier, q-1} register, one step per cycle for exactly 32 cycles, then enter DONE.
REQ-007 DIV SHALL run restoring division on operand magnitudes, one quotient bit per cycle for exactly 32 cycles, then enter DONE.
REQ-008 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-009 Divide by zero: if b == 0 when DIV is entered, the block SHALL skip iteration and go to DONE on the next cycle with divZero=1 and hi/lo unchanged.
REQ-010 The case -2^31 / -1 SHALL give lo=32'h8000_0000, hi=0, divZero=0.
REQ-011 Latency: with start accepted on edge N, done SHALL be high during the cycle after edge N+33 (both ops, b != 0); divide by zero SHALL assert done after edge N+2.
REQ-012 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE; a start in DONE SHALL be ignored.
REQ-013 hi/lo SHALL update only on entry to DONE and SHALL hold their values otherwise, including across later ignored starts.
REQ-014 divZero SHALL clear when a new start is accepted and SHALL set only on the DONE entry of a divide-by-zero.
REQ-015 busy SHALL be 0 only in IDLE.

Reset
REQ-016 When reset=1 at a rising edge, the block SHALL force state=IDLE, hi=0, lo=0, done=0, divZero=0, busy=0 and counter=0, taking priority over any start.
REQ-017 Reset asserted mid-operation SHALL abort the operation with no done pulse, and no partial results SHALL reach hi/lo.

Structure
REQ-018 Package mult_div_pkg SHALL hold the state enum (IDLE, MULT, DIV, DONE), WORD_W=32 and ITER_COUNT=32.
REQ-019 One combinational sub-module, booth_step, SHALL perform a single Booth add/sub plus arithmetic shift of the 65-bit register; the division step SHALL stay inline.
REQ-020 The iteration counter SHALL be 6 bits wide and compare against ITER_COUNT-1.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- multStart, a=7, b=-3 -> done 33 cycles later, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- multStart, a=32'h8000_0000, b=32'h8000_0000 -> hi=32'h4000_0000, lo=0.
- divStart, a=-17, b=5 -> lo=-3 (32'hFFFF_FFFD), hi=-2 (32'hFFFF_FFFE), divZero=0.
- divStart, a=100, b=0 -> done 2 cycles after start, divZero=1, hi/lo keep previous values; next multStart clears divZero.
- multStart and divStart together (a=6, b=4), then divStart while busy -> one multiply result only (hi=0, lo=24), one done pulse.
- Reset asserted 10 cycles into a divide -> busy=0, done never pulses, hi=lo=0 on the following cycle.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the signed multiply/divide unit.
package mult_div_pkg;

    localparam int WORD_W     = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;
    localparam int PROD_W     = 2 * WORD_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] mag(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub on the accumulator, then arithmetic shift right of {acc, mplier, q-1}.
module booth_step
    import mult_div_pkg::*;
(
    input  logic [PROD_W-1:0] i_prod,
    input  logic [WORD_W-1:0] i_mcand,
    output logic [PROD_W-1:0] o_prod
);

    logic [WORD_W:0] w_acc_ext;
    logic [WORD_W:0] w_mcand_ext;
    logic [WORD_W:0] w_sum;

    // The sum is one bit wider so -2^31 * -2^31 shifts in the true sign rather than an overflowed one.
    always_comb begin
        w_acc_ext   = {i_prod[PROD_W-1], i_prod[PROD_W-1:WORD_W+1]};
        w_mcand_ext = {i_mcand[WORD_W-1], i_mcand};
        unique case (i_prod[1:0])
            2'b01:   w_sum = w_acc_ext + w_mcand_ext;
            2'b10:   w_sum = w_acc_ext - w_mcand_ext;
            default: w_sum = w_acc_ext;
        endcase
        o_prod = {w_sum, i_prod[WORD_W:1]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth) and divide (restoring) unit; 32 iterations per operation.
//
// state | meaning
// IDLE  | waiting for multStart/divStart; operands latched on accept
// MULT  | first cycle loads the Booth register, then 32 Booth steps
// DIV   | first cycle loads magnitudes, then b==0 exits or 32 restoring steps
// DONE  | one-cycle done pulse, results already in hi/lo
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              multStart,
    input  logic              divStart,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              divZero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_setup;
    logic [WORD_W-1:0]   r_opa;
    logic [WORD_W-1:0]   r_opb;
    logic [PROD_W-1:0]   r_prod;
    logic [WORD_W-1:0]   r_rem;
    logic [WORD_W-1:0]   r_quo;
    logic [WORD_W-1:0]   r_dvs;
    logic                r_qneg;
    logic                r_rneg;

    logic [PROD_W-1:0]   w_booth_next;
    logic [WORD_W:0]     w_rem_sh;
    logic [WORD_W-1:0]   w_diff;
    logic                w_qbit;
    logic [WORD_W-1:0]   w_rem_next;
    logic [WORD_W-1:0]   w_quo_next;
    logic [WORD_W-1:0]   w_rem_signed;
    logic [WORD_W-1:0]   w_quo_signed;

    booth_step u_booth_step (
        .i_prod  (r_prod),
        .i_mcand (r_opa),
        .o_prod  (w_booth_next)
    );

    // Remainder stays below the divisor, so the low 32 bits of the difference are exact when w_qbit is set.
    always_comb begin
        w_rem_sh     = {r_rem, r_quo[WORD_W-1]};
        w_qbit       = (w_rem_sh >= {1'b0, r_dvs});
        w_diff       = w_rem_sh[WORD_W-1:0] - r_dvs;
        w_rem_next   = w_qbit ? w_diff : w_rem_sh[WORD_W-1:0];
        w_quo_next   = {r_quo[WORD_W-2:0], w_qbit};
        w_rem_signed = r_rneg ? (~w_rem_next + 1'b1) : w_rem_next;
        w_quo_signed = r_qneg ? (~w_quo_next + 1'b1) : w_quo_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_setup <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (multStart || divStart) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_cnt   <= '0;
                        r_setup <= 1'b1;
                        divZero <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= multStart ? MULT : DIV;
                    end
                end
                MULT: begin
                    if (r_setup) begin
                        r_prod  <= {{WORD_W{1'b0}}, r_opb, 1'b0};
                        r_setup <= 1'b0;
                    end else begin
                        r_prod <= w_booth_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            hi      <= w_booth_next[PROD_W-1:WORD_W+1];
                            lo      <= w_booth_next[WORD_W:1];
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (r_setup) begin
                        r_quo   <= mag(r_opa);
                        r_dvs   <= mag(r_opb);
                        r_rem   <= '0;
                        r_qneg  <= r_opa[WORD_W-1] ^ r_opb[WORD_W-1];
                        r_rneg  <= r_opa[WORD_W-1];
                        r_setup <= 1'b0;
                    end else if (r_dvs == '0) begin
                        divZero <= 1'b1;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            hi      <= w_rem_signed;
                            lo      <= w_quo_signed;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops against an arithmetic model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        multStart;
    logic        divStart;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divZero;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .multStart (multStart),
        .divStart  (divStart),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .divZero   (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
    endfunction

    // Returns {remainder, quotient}; longint division truncates toward zero, % follows the dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {32'(r), 32'(q)};
    endfunction

    task automatic issue(input logic m, input logic d, input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        multStart = m;
        divStart  = d;
        a         = ia;
        b         = ib;
        @(posedge clk);
        #1;
        multStart = 1'b0;
        divStart  = 1'b0;
    endtask

    // Edges counted from the accept edge until done is seen; -1 when the budget expires.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; multStart = 1'b1; a = 32'd7; b = 32'd3;
        step_cycle();
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (divZero !== 1'b0)  begin errors++; $display("FAIL reset_divzero: got %b expected 0", divZero); end
        @(negedge clk);
        reset = 1'b0; multStart = 1'b0;
        step_cycle();
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult_directed();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] eh [2];
        logic [31:0] el [2];
        int lat;
        va = '{32'd7, 32'h8000_0000};
        vb = '{32'hFFFF_FFFD, 32'h8000_0000};
        eh = '{32'hFFFF_FFFF, 32'h4000_0000};
        el = '{32'hFFFF_FFEB, 32'h0000_0000};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, va[i], vb[i]);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_%0d: got %b expected 1", i, busy); end
            wait_done(lat);
            checks++; if (lat != 33)     begin errors++; $display("FAIL mult_latency_%0d: got %0d expected 33", i, lat); end
            checks++; if (hi !== eh[i])  begin errors++; $display("FAIL mult_hi_%0d: got %h expected %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i])  begin errors++; $display("FAIL mult_lo_%0d: got %h expected %h", i, lo, el[i]); end
            step_cycle();
            checks++; if (done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL mult_done_len_%0d: got done=%b busy=%b expected 0 0", i, done, busy); end
            exp_hi = eh[i];
            exp_lo = el[i];
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] eh [4];
        logic [31:0] el [4];
        int lat;
        va = '{32'hFFFF_FFEF, 32'h8000_0000, 32'd100, 32'd17};
        vb = '{32'd5,         32'hFFFF_FFFF, 32'd7,   32'hFFFF_FFFB};
        eh = '{32'hFFFF_FFFE, 32'd0,         32'd2,   32'd2};
        el = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14,  32'hFFFF_FFFD};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, va[i], vb[i]);
            wait_done(lat);
            checks++; if (lat != 33)        begin errors++; $display("FAIL div_latency_%0d: got %0d expected 33", i, lat); end
            checks++; if (hi !== eh[i])     begin errors++; $display("FAIL div_hi_%0d: got %h expected %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i])     begin errors++; $display("FAIL div_lo_%0d: got %h expected %h", i, lo, el[i]); end
            checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL div_divzero_%0d: got %b expected 0", i, divZero); end
            step_cycle();
            exp_hi = eh[i];
            exp_lo = el[i];
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(1'b1, 1'b0, 32'd9, 32'hFFFF_FFFE);
        wait_done(lat);
        step_cycle();
        issue(1'b0, 1'b1, 32'd100, 32'd0);
        wait_done(lat);
        checks++; if (lat != 2)               begin errors++; $display("FAIL dz_latency: got %0d expected 2", lat); end
        checks++; if (divZero !== 1'b1)       begin errors++; $display("FAIL dz_flag: got %b expected 1", divZero); end
        checks++; if (hi !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL dz_hi_hold: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEE)   begin errors++; $display("FAIL dz_lo_hold: got %h expected ffffffee", lo); end
        step_cycle();
        checks++; if (done !== 1'b0 || divZero !== 1'b1)
            begin errors++; $display("FAIL dz_after: got done=%b divZero=%b expected 0 1", done, divZero); end
        issue(1'b1, 1'b0, 32'd3, 32'd5);
        checks++; if (divZero !== 1'b0)       begin errors++; $display("FAIL dz_clear: got %b expected 0", divZero); end
        wait_done(lat);
        checks++; if (lo !== 32'd15 || hi !== 32'd0)
            begin errors++; $display("FAIL dz_next_mult: got %h_%h expected 00000000_0000000f", hi, lo); end
        step_cycle();
        exp_hi = 32'd0;
        exp_lo = 32'd15;
    endtask

    task automatic test_both_start();
        int lat;
        int pulses;
        issue(1'b1, 1'b1, 32'd6, 32'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        divStart = 1'b1; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        #1;
        divStart = 1'b0;
        wait_done(lat);
        lat += 4;
        checks++; if (lat != 33)      begin errors++; $display("FAIL both_latency: got %0d expected 33", lat); end
        checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL both_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd24)  begin errors++; $display("FAIL both_lo: got %h expected 18", lo); end
        // Start presented during the DONE cycle must be dropped.
        multStart = 1'b1; a = 32'd5; b = 32'd5;
        step_cycle();
        multStart = 1'b0;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL done_start_busy: got %b expected 0", busy); end
        pulses = 0;
        repeat (40) begin
            step_cycle();
            if (done) pulses++;
        end
        checks++; if (pulses != 0)    begin errors++; $display("FAIL both_extra_done: got %0d pulses expected 0", pulses); end
        checks++; if (hi !== 32'd0 || lo !== 32'd24)
            begin errors++; $display("FAIL both_hold: got %h_%h expected 00000000_00000018", hi, lo); end
        exp_hi = 32'd0;
        exp_lo = 32'd24;
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        issue(1'b1, 1'b0, 32'd123, 32'hFFFF_FFFF);
        wait_done(lat);
        step_cycle();
        issue(1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0)
            begin errors++; $display("FAIL rmid_hilo: got %h_%h expected 0_0", hi, lo); end
        pulses = 0;
        repeat (40) begin
            step_cycle();
            if (done) pulses++;
        end
        checks++; if (pulses != 0)    begin errors++; $display("FAIL rmid_done: got %0d pulses expected 0", pulses); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0)
            begin errors++; $display("FAIL rmid_hold: got %h_%h expected 0_0", hi, lo); end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic [63:0] res;
        logic        is_mult;
        logic        exp_dz;
        int          exp_lat;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            is_mult = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(0, 16)) - 32'd8;
                3: ra = 32'($urandom_range(0, 64)) - 32'd32;
                default: ;
            endcase
            exp_dz  = 1'b0;
            exp_lat = 33;
            if (is_mult) begin
                res = ref_mul(ra, rb);
                exp_hi = res[63:32];
                exp_lo = res[31:0];
            end else if (rb == 32'd0) begin
                exp_dz  = 1'b1;
                exp_lat = 2;
            end else begin
                res = ref_div(ra, rb);
                exp_hi = res[63:32];
                exp_lo = res[31:0];
            end
            issue(is_mult, ~is_mult, ra, rb);
            wait_done(lat);
            checks++; if (lat != exp_lat)    begin errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", i, lat, exp_lat); end
            checks++; if (hi !== exp_hi)     begin errors++; $display("FAIL rand_hi_%0d: a=%h b=%h mult=%b got %h expected %h", i, ra, rb, is_mult, hi, exp_hi); end
            checks++; if (lo !== exp_lo)     begin errors++; $display("FAIL rand_lo_%0d: a=%h b=%h mult=%b got %h expected %h", i, ra, rb, is_mult, lo, exp_lo); end
            checks++; if (divZero !== exp_dz) begin errors++; $display("FAIL rand_divzero_%0d: got %b expected %b", i, divZero, exp_dz); end
            step_cycle();
        end
    endtask

    initial begin
        reset     = 1'b1;
        multStart = 1'b0;
        divStart  = 1'b0;
        a         = '0;
        b         = '0;
        exp_hi    = '0;
        exp_lo    = '0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_both_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
